adder_pipe_param: RTL and testbench
===================================

# adder_pipe_param

Parametrised, pipelined ripple-carry adder/subtractor. Operands of WIDTH bits are split into SLICE-bit slices. One slice is resolved per pipeline stage, and the carry is registered between stages. This gives one result per clock at full throughput, with a short per-stage carry path. It is the drop-in arithmetic unit for datapaths wider than 8 bits or clocked faster than a flat ripple chain allows. It adds a per-transaction subtract mode and a valid/ready handshake with backpressure.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; must be a positive multiple of SLICE (elaboration error otherwise)
- SLICE, 2, bits resolved per pipeline stage; STAGES = WIDTH/SLICE

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  0: sum = a + b + cin; 1: sum = a - b (cin ignored)
- in_valid  input  1  a/b/cin/sub valid this cycle
- in_ready  output  1  block accepts input this cycle
- sum  output  WIDTH  result, registered
- out  output  1  carry-out; in subtract mode 1 = no borrow (a >= b unsigned)
- out_valid  output  1  sum/out valid
- out_ready  input  1  downstream accepts result

## Operation
- Pipeline enable: en = !out_valid || out_ready. in_ready = en (combinational from out_valid and out_ready only, never from in_valid).
- Accept when in_valid && in_ready at a rising edge. Stage 0 then captures:
  - the slice 0 sum and carry;
  - a[WIDTH-1:SLICE] and the effective B, where effective B = b in add mode or ~b in subtract mode;
  - the effective carry-in, which is cin in add mode or 1 in subtract mode.
- Stage k (1..STAGES-1) adds slice k of the stored operands with the registered carry from stage k-1. It registers the slice sum and the new carry. It carries forward the higher slices not yet consumed and the already-computed lower sum bits (deskew).
- The last stage drives sum (all slices aligned) and out (the final carry).
- Each stage holds its own valid bit; bubbles propagate and are not compressed.
- en = 0: every stage register, including the valid bits, holds its value; no new input is accepted.
- Arithmetic is modulo 2^WIDTH. out is the true bit WIDTH of a + effective B + effective carry-in.
- STAGES = 1 (SLICE = WIDTH) is legal: a single registered adder.

## Timing
- Reset: out_valid = 0, all internal valid bits = 0, sum = 0, out = 0. in_ready = 1 while rst is high (out_valid = 0).
- Reset mid-operation: all in-flight transactions are discarded; no partial result ever appears on sum/out.
- Latency: input accepted at edge N; out_valid = 1 with its result after edge N + STAGES - 1.
  - WIDTH=8, SLICE=2: result visible after edge N+3.
- Throughput: 1 transaction/cycle while out_ready = 1.
- Backpressure: out_valid=1 && out_ready=0 freezes the whole pipeline and drops in_ready the same cycle. sum/out/out_valid stay stable until out_ready = 1.
- Simultaneous accept and drain at one edge (in_valid, in_ready, out_ready all high) is normal flow: the result leaves and the new input enters stage 0.
- Order of results equals order of acceptance; no reordering.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, sum=0, out=0 throughout; nothing emerges after release unless new input is presented.
- Add, WIDTH=8/SLICE=2: a=0xFF, b=0x01, cin=0, sub=0, accepted at edge N -> after edge N+3: sum=0x00, out=1. Then a=0x55, b=0xAA, cin=1 -> sum=0x00, out=1.
- Subtract: a=0x10, b=0x01, sub=1 -> sum=0x0F, out=1. a=0x01, b=0x02, sub=1 -> sum=0xFF, out=0. cin is ignored in both.
- Streaming plus backpressure: 16 back-to-back random adds with out_ready toggled pseudo-randomly -> results match a reference model in order, no loss or duplication, sum stable while stalled, in_ready = !out_valid || out_ready every cycle.
- Reset mid-flight: 3 transactions accepted, rst at the next edge -> zero outputs, none of the 3 results ever appear.
- Parameter sweep: WIDTH=32/SLICE=4 (8 stages) and WIDTH=16/SLICE=16 (1 stage) -> 0xFFFFFFFF+1 gives sum=0, out=1 after 7 edges; the 16-bit case gives its result after edge N.

Source files
------------

// File: rtl/adder_pipe_param.sv
// Pipelined ripple-carry adder/subtractor.
// Operands are resolved SLICE bits per stage, with the carry registered between stages.
// Untouched operand slices travel down the pipe shifted so that the next slice
// to add always sits at bit 0. Finished sum slices enter at the top of the sum
// register and are shifted right each stage, so the final stage holds the
// complete, aligned result.
module adder_pipe_param #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = WIDTH / SLICE;

  generate
    if ((SLICE <= 0) || (WIDTH <= 0) || ((WIDTH % SLICE) != 0)) begin : g_badParam
      $error("adder_pipe_param: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  // Per-stage registered state
  logic             r_valid [STAGES];
  logic             r_carry [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic [WIDTH-1:0] r_aRem  [STAGES];
  logic [WIDTH-1:0] r_bRem  [STAGES];

  // Per-stage inputs, as seen by the stage that is about to capture them
  logic             w_validIn [STAGES];
  logic             w_carryIn [STAGES];
  logic [WIDTH-1:0] w_aIn     [STAGES];
  logic [WIDTH-1:0] w_bIn     [STAGES];
  logic [WIDTH-1:0] w_sumIn   [STAGES];
  logic [SLICE:0]   w_sliceSum[STAGES];
  logic             w_en;

  // The whole pipe advances unless a finished result is waiting on a stalled consumer
  assign w_en      = !r_valid[STAGES-1] || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_valid[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign out       = r_carry[STAGES-1];

  // Route each stage's inputs: stage 0 from the ports (subtract becomes a + ~b + 1), later stages from their predecessor
  always_comb begin
    w_validIn[0] = in_valid;
    w_aIn[0]     = a;
    w_bIn[0]     = sub ? ~b : b;
    w_carryIn[0] = sub ? 1'b1 : cin;
    w_sumIn[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_validIn[k] = r_valid[k-1];
      w_aIn[k]     = r_aRem[k-1];
      w_bIn[k]     = r_bRem[k-1];
      w_carryIn[k] = r_carry[k-1];
      w_sumIn[k]   = r_sum[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_sliceSum[k] = {1'b0, w_aIn[k][SLICE-1:0]}
                    + {1'b0, w_bIn[k][SLICE-1:0]}
                    + {{SLICE{1'b0}}, w_carryIn[k]};
    end
  end

  // Advance every stage together; data registers only load behind a valid bit so bubbles leave results untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_carry[k] <= 1'b0;
        r_sum[k]   <= '0;
        r_aRem[k]  <= '0;
        r_bRem[k]  <= '0;
      end
    end else if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_validIn[k];
        if (w_validIn[k]) begin
          r_carry[k] <= w_sliceSum[k][SLICE];
          r_sum[k]   <= (w_sumIn[k] >> SLICE)
                      | (WIDTH'(w_sliceSum[k][SLICE-1:0]) << (WIDTH - SLICE));
          r_aRem[k]  <= w_aIn[k] >> SLICE;
          r_bRem[k]  <= w_bIn[k] >> SLICE;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe_param.sv
// Self-checking bench for adder_pipe_param: 8/2 (4 stages), 32/4 (8 stages), 16/16 (1 stage).
module tb_adder_pipe_param;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // 8-bit, 4-stage instance
  logic [7:0] a8, b8, sum8;
  logic       cin8, sub8, iv8, ir8, out8, ov8, or8;

  adder_pipe_param #(.WIDTH(8), .SLICE(2)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .in_valid(iv8), .in_ready(ir8), .sum(sum8), .out(out8),
    .out_valid(ov8), .out_ready(or8)
  );

  // 32-bit, 8-stage instance
  logic [31:0] a32, b32, sum32;
  logic        cin32, sub32, iv32, ir32, out32, ov32, or32;

  adder_pipe_param #(.WIDTH(32), .SLICE(4)) dut32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .in_valid(iv32), .in_ready(ir32), .sum(sum32), .out(out32),
    .out_valid(ov32), .out_ready(or32)
  );

  // 16-bit, single-stage instance
  logic [15:0] a16, b16, sum16;
  logic        cin16, sub16, iv16, ir16, out16, ov16, or16;

  adder_pipe_param #(.WIDTH(16), .SLICE(16)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .in_valid(iv16), .in_ready(ir16), .sum(sum16), .out(out16),
    .out_valid(ov16), .out_ready(or16)
  );

  // Reference: {carry/no-borrow, result} from plain arithmetic
  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic sub);
    if (sub) return {(a >= b), 8'(a - b)};
    return 9'(a) + 9'(b) + 9'(cin);
  endfunction

  logic [8:0] scoreQ[$];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One isolated 8-bit transaction: checks latency, sum and carry
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, input string name);
    logic [8:0] exp;
    int lat;
    exp  = model8(a, b, cin, sub);
    a8   = a; b8 = b; cin8 = cin; sub8 = sub; iv8 = 1'b1; or8 = 1'b1;
    step();
    iv8 = 1'b0;
    lat = 0;
    while (ov8 !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("[TB] FAIL %s_latency: got %0d edges, expected 3", name, lat);
    end
    checks++;
    if ({out8, sum8} !== exp) begin
      errors++;
      $display("[TB] FAIL %s_result: got out=%b sum=%h, expected out=%b sum=%h",
               name, out8, sum8, exp[8], exp[7:0]);
    end
    step();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    iv8 = 1'b1; a8 = 8'h5A; b8 = 8'hC3; cin8 = 1'b1; sub8 = 1'b0; or8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (ov8 !== 1'b0 || sum8 !== 8'h00 || out8 !== 1'b0 || ir8 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_state: got ov=%b sum=%h out=%b ir=%b, expected 0 00 0 1",
                 ov8, sum8, out8, ir8);
      end
    end
    rst = 1'b0;
    iv8 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (ov8 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_idle: got out_valid=%b, expected 0", ov8);
      end
    end
  endtask

  task automatic test_add;
    run8(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
    run8(8'h55, 8'hAA, 1'b1, 1'b0, "add_55_aa_c1");
    run8(8'h3C, 8'h47, 1'b1, 1'b0, "add_3c_47_c1");
  endtask

  task automatic test_sub;
    run8(8'h10, 8'h01, 1'b1, 1'b1, "sub_10_01");
    run8(8'h01, 8'h02, 1'b1, 1'b1, "sub_01_02");
    run8(8'h80, 8'h80, 1'b0, 1'b1, "sub_equal");
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [7:0] heldSum = '0;
    logic heldOut = 1'b0;
    logic [8:0] exp;
    scoreQ.delete();
    while ((sent < 16 || scoreQ.size() != 0) && cyc < 500) begin
      or8 = (($urandom % 4) != 0);
      if (sent < 16) begin
        iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
        cin8 = 1'($urandom); sub8 = 1'($urandom);
      end else begin
        iv8 = 1'b0;
      end
      #1;
      checks++;
      if (ir8 !== (!ov8 || or8)) begin
        errors++;
        $display("[TB] FAIL stream_in_ready: got %b, expected %b", ir8, (!ov8 || or8));
      end
      if (stalled) begin
        checks++;
        if (ov8 !== 1'b1 || sum8 !== heldSum || out8 !== heldOut) begin
          errors++;
          $display("[TB] FAIL stream_stall_hold: got ov=%b sum=%h out=%b, expected 1 %h %b",
                   ov8, sum8, out8, heldSum, heldOut);
        end
      end
      if (ov8 === 1'b1 && or8) begin
        checks++;
        if (scoreQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL stream_extra: got unexpected result sum=%h, expected none", sum8);
        end else begin
          exp = scoreQ.pop_front();
          if ({out8, sum8} !== exp) begin
            errors++;
            $display("[TB] FAIL stream_result: got out=%b sum=%h, expected out=%b sum=%h",
                     out8, sum8, exp[8], exp[7:0]);
          end
        end
        got++;
      end
      stalled = (ov8 === 1'b1) && !or8;
      heldSum = sum8;
      heldOut = out8;
      if (iv8 && ir8 === 1'b1) begin
        scoreQ.push_back(model8(a8, b8, cin8, sub8));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    checks++;
    if (got != 16 || scoreQ.size() != 0 || sent != 16) begin
      errors++;
      $display("[TB] FAIL stream_count: got %0d results (%0d sent, %0d pending), expected 16",
               got, sent, scoreQ.size());
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ov8 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stream_drain_idle: got out_valid=%b, expected 0", ov8);
      end
    end
  endtask

  task automatic test_reset_midflight;
    or8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv8 = 1'b1; a8 = 8'h21 + 8'(i); b8 = 8'h13; cin8 = 1'b1; sub8 = 1'b0;
      step();
    end
    iv8 = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if (ov8 !== 1'b0 || sum8 !== 8'h00 || out8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midflight_reset: got ov=%b sum=%h out=%b, expected 0 00 0",
               ov8, sum8, out8);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (ov8 !== 1'b0 || sum8 !== 8'h00) begin
        errors++;
        $display("[TB] FAIL midflight_ghost: got ov=%b sum=%h, expected 0 00", ov8, sum8);
      end
    end
  endtask

  task automatic test_sweep;
    logic [32:0] exp33;
    logic [16:0] exp17;
    int lat;
    for (int t = 0; t < 3; t++) begin
      if (t == 0) begin
        a32 = 32'hFFFF_FFFF; b32 = 32'h1; cin32 = 1'b0; sub32 = 1'b0;
      end else begin
        a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = (t == 2);
      end
      exp33 = sub32 ? {(a32 >= b32), 32'(a32 - b32)} : 33'(a32) + 33'(b32) + 33'(cin32);
      iv32 = 1'b1; or32 = 1'b1;
      step();
      iv32 = 1'b0;
      lat = 0;
      while (ov32 !== 1'b1 && lat < 30) begin
        step();
        lat++;
      end
      checks++;
      if (lat !== 7 || {out32, sum32} !== exp33) begin
        errors++;
        $display("[TB] FAIL sweep32_%0d: got lat=%0d out=%b sum=%h, expected lat=7 out=%b sum=%h",
                 t, lat, out32, sum32, exp33[32], exp33[31:0]);
      end
      step();
    end
    for (int t = 0; t < 3; t++) begin
      if (t == 0) begin
        a16 = 16'hFFFF; b16 = 16'h1; cin16 = 1'b0; sub16 = 1'b0;
      end else begin
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = (t == 2);
      end
      exp17 = sub16 ? {(a16 >= b16), 16'(a16 - b16)} : 17'(a16) + 17'(b16) + 17'(cin16);
      iv16 = 1'b1; or16 = 1'b1;
      step();
      iv16 = 1'b0;
      checks++;
      if (ov16 !== 1'b1 || {out16, sum16} !== exp17) begin
        errors++;
        $display("[TB] FAIL sweep16_%0d: got ov=%b out=%b sum=%h, expected ov=1 out=%b sum=%h",
                 t, ov16, out16, sum16, exp17[16], exp17[15:0]);
      end
      step();
    end
  endtask

  initial begin
    rst  = 1'b1;
    a8   = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0; iv8  = 1'b0; or8  = 1'b1;
    a32  = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; iv32 = 1'b0; or32 = 1'b1;
    a16  = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; iv16 = 1'b0; or16 = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_midflight();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
